banked_file_ram: RTL
====================

Name: banked_file_ram

Overview:
- Parametrised successor to the flat file-register RAM.
- Adds PIC16F-style bank addressing with a common region that aliases into bank 0.
- Adds a hardware clear sequence after reset, explicit read/write strobes and a read-valid flag.
- Sits between the core's file-address decode (bank bits + 7-bit local address) and the special-function-register mux.

Parameters:
- BANK_BITS, 2: number of bank-select bits; bank count = 2**BANK_BITS.
- LOCAL_WIDTH, 7: address bits within one bank.
- DATA_WIDTH, 8: word width.
- COMMON_SIZE, 16: number of top-of-bank locations shared across all banks. Must be less than 2**LOCAL_WIDTH; 0 disables aliasing.
- CLEAR_ON_RESET, 1: 1 = zero-fill the whole array after reset; 0 = skip the clear.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bank  in  BANK_BITS  bank select.
- addr  in  LOCAL_WIDTH  address within the bank.
- rd_en  in  1  read strobe.
- wr_en  in  1  write strobe.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  data_out updated by the read accepted last cycle.
- busy  out  1  requests ignored this cycle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Array: DEPTH = 2**(BANK_BITS+LOCAL_WIDTH) words, registered synchronous RAM, no reset on the array itself.
- Address map:
  - phys = {bank, addr}.
  - If addr >= 2**LOCAL_WIDTH - COMMON_SIZE, then phys = {0, addr}, so every bank hits bank 0's copy.
- Reset values: data_out = 0, rd_valid = 0, busy = CLEAR_ON_RESET, clear counter = 0.
- State machine: CLEAR, IDLE, RMW (RMW exists only with the optional feature).
  - Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
- CLEAR:
  - Writes 0 to phys = counter each cycle and increments the counter.
  - After writing DEPTH-1, moves to IDLE. busy is low on the following cycle.
  - Total busy time = DEPTH cycles after rst_n deasserts.
  - rd_en and wr_en are ignored and dropped (no queueing); rd_valid stays 0.
- IDLE:
  - wr_en writes data_in to phys at the clock edge.
  - rd_en latches mem[phys] into data_out at the edge; rd_valid = 1 for exactly the next cycle. Read latency is 1.
  - Without rd_en, data_out holds its value and rd_valid = 0.
- Same-cycle rd_en and wr_en to the same phys: read returns the OLD contents; the write commits.
  - Also applies to aliased pairs, e.g. bank 1 addr 0x70 vs bank 3 addr 0x70.
- rst_n asserted mid-CLEAR or mid-RMW: immediate return to reset values. CLEAR restarts from address 0. A half-done RMW write is discarded.
- Counter width is BANK_BITS+LOCAL_WIDTH+1, so the terminal compare does not wrap.

Optional Feature:
- Macro: BANKED_FILE_RAM_BITMASK_EN.
- Defined:
  - Adds input wr_mask [DATA_WIDTH].
  - mask all-ones: normal single-cycle write.
  - mask zero: no write.
  - Any other mask: two-cycle read-modify-write. Cycle 1 reads mem[phys] and latches phys, data_in and mask; the FSM enters RMW with busy = 1. Cycle 2 writes (old & ~mask) | (data_in & mask) and returns to IDLE.
  - An rd_en issued with the RMW-starting write behaves as in IDLE (returns old data).
  - Inputs presented during RMW are ignored.
  - Supports BSF/BCF without a core-side read.
- Undefined: no wr_mask port, no RMW state; all writes are full-width.

Decomposition:
- Package banked_file_ram_pkg holds:
  - the state encoding (CLEAR, IDLE, RMW);
  - a DEPTH computation function;
  - the common-region base computation.
- One natural sub-module, file_ram_addr_map: combinational bank/addr to phys mapping, reusable by the indirect-address (FSR) path.

Test Plan:
- Reset, defaults (DEPTH 512): rst_n low, then high. busy = 1 for exactly 512 cycles. Reads of {2,0x20} and {3,0x6F} afterwards return 0x00.
- Banked isolation: write 0xA5 to bank 1 addr 0x20 and 0x5A to bank 2 addr 0x20. Reads return 0xA5 and 0x5A respectively. rd_valid is high one cycle after each rd_en.
- Common alias: write 0x3C to bank 3 addr 0x75. Read bank 0 addr 0x75 returns 0x3C. Read bank 2 addr 0x6F is unaffected (still 0x00).
- Read-during-write: mem{1,0x10} = 0x11. Same cycle, rd_en + wr_en with data 0x22. data_out = 0x11; the next read returns 0x22.
- Reset mid-clear: pull rst_n low at clear cycle 200, release. busy lasts a full 512 cycles again; all words read 0.
- BITMASK_EN: mem = 0xF0. Write data 0x0F with mask 0x03. busy is high for one cycle; a read then returns 0xF3. Mask 0x00 leaves 0xF3 unchanged.

Source files
------------

// File: rtl/banked_file_ram_pkg.sv
// Shared definitions for the banked file-register RAM: FSM states and geometry helpers.
// No logic of its own; pure types and constant functions.
// Used by both the top level and the bank/address mapper.
package banked_file_ram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RMW   = 2'd2
    } ram_state_t;

    // Total word count across all banks.
    function automatic int calc_depth(input int bank_bits, input int local_width);
        return 1 << (bank_bits + local_width);
    endfunction

    // First local address of the common region shared by every bank.
    function automatic int common_base(input int local_width, input int common_size);
        return (1 << local_width) - common_size;
    endfunction

endpackage

// File: rtl/file_ram_addr_map.sv
// Maps {bank, local addr} to a physical word index, folding the common region onto bank 0.
// Latency: purely combinational.
// Backpressure: none; the mapping is stateless.
module file_ram_addr_map
    import banked_file_ram_pkg::*;
#(
    parameter int BANK_BITS   = 2,
    parameter int LOCAL_WIDTH = 7,
    parameter int COMMON_SIZE = 16
) (
    input  logic [BANK_BITS-1:0]             bank,
    input  logic [LOCAL_WIDTH-1:0]           addr,
    output logic [BANK_BITS+LOCAL_WIDTH-1:0] phys
);

    localparam int BASE = common_base(LOCAL_WIDTH, COMMON_SIZE);

    logic in_common;

    // Top-of-bank locations ignore the bank bits so every bank shares bank 0's copy.
    always_comb begin
        in_common = (COMMON_SIZE > 0) && (int'(addr) >= BASE);
        phys      = in_common ? {{BANK_BITS{1'b0}}, addr} : {bank, addr};
    end

endmodule

// File: rtl/banked_file_ram.sv
// Banked file-register RAM with common-region aliasing, post-reset zero fill and read-valid flag.
// Latency: reads return one cycle after rd_en; masked (partial) writes take two cycles.
// Backpressure: busy high means rd_en/wr_en are dropped, not queued. Optional macro BANKED_FILE_RAM_BITMASK_EN adds wr_mask.
module banked_file_ram
    import banked_file_ram_pkg::*;
#(
    parameter int BANK_BITS      = 2,
    parameter int LOCAL_WIDTH    = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int COMMON_SIZE    = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BANK_BITS-1:0]   bank,
    input  logic [LOCAL_WIDTH-1:0] addr,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
`ifdef BANKED_FILE_RAM_BITMASK_EN
    input  logic [DATA_WIDTH-1:0]  wr_mask,
`endif
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   rd_valid,
    output logic                   busy
);

    localparam int AW    = BANK_BITS + LOCAL_WIDTH;
    localparam int DEPTH = calc_depth(BANK_BITS, LOCAL_WIDTH);

    // One extra bit so the terminal compare can never wrap.
    typedef logic [AW:0] cnt_t;
    localparam cnt_t CLR_LAST = cnt_t'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ram_state_t            state;
    cnt_t                  clr_cnt;
    logic [AW-1:0]         phys;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef BANKED_FILE_RAM_BITMASK_EN
    logic [AW-1:0]         rmw_phys;
    logic [DATA_WIDTH-1:0] rmw_dat;
    logic [DATA_WIDTH-1:0] rmw_mask;
    logic [DATA_WIDTH-1:0] rmw_old;
    logic                  mask_full;
    logic                  mask_part;

    assign mask_full = (wr_mask == {DATA_WIDTH{1'b1}});
    assign mask_part = (wr_mask != {DATA_WIDTH{1'b0}}) && !mask_full;
`endif

    file_ram_addr_map #(
        .BANK_BITS   (BANK_BITS),
        .LOCAL_WIDTH (LOCAL_WIDTH),
        .COMMON_SIZE (COMMON_SIZE)
    ) u_addr_map (
        .bank (bank),
        .addr (addr),
        .phys (phys)
    );

    // Select the single write port source: clear sweep, direct write, or RMW merge.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = phys;
        mem_wdata = data_in;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt[AW-1:0];
                mem_wdata = '0;
            end
            ST_IDLE: begin
`ifdef BANKED_FILE_RAM_BITMASK_EN
                mem_we = wr_en && mask_full;
`else
                mem_we = wr_en;
`endif
            end
`ifdef BANKED_FILE_RAM_BITMASK_EN
            ST_RMW: begin
                mem_we    = 1'b1;
                mem_waddr = rmw_phys;
                mem_wdata = (rmw_old & ~rmw_mask) | (rmw_dat & rmw_mask);
            end
`endif
            default: begin
                mem_we = 1'b0;
            end
        endcase
        // Nothing may land in the array while reset is held.
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    // Array write port; the storage itself is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM: clear sweep, read capture (old data on same-cycle write), RMW sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            busy     <= (CLEAR_ON_RESET != 0);
            data_out <= '0;
            rd_valid <= 1'b0;
            clr_cnt  <= '0;
`ifdef BANKED_FILE_RAM_BITMASK_EN
            rmw_phys <= '0;
            rmw_dat  <= '0;
            rmw_mask <= '0;
            rmw_old  <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + cnt_t'(1);
                    if (clr_cnt == CLR_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (rd_en) begin
                        data_out <= mem[phys];
                        rd_valid <= 1'b1;
                    end
`ifdef BANKED_FILE_RAM_BITMASK_EN
                    if (wr_en && mask_part) begin
                        rmw_phys <= phys;
                        rmw_dat  <= data_in;
                        rmw_mask <= wr_mask;
                        rmw_old  <= mem[phys];
                        state    <= ST_RMW;
                        busy     <= 1'b1;
                    end
`endif
                end
`ifdef BANKED_FILE_RAM_BITMASK_EN
                ST_RMW: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
